// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: issues PC requests to instruction memory, buffers tagged
// responses in order and drives the IF/ID register. Optional macro: FETCH_ALIGN_CHECK_EN.
module fetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] pc,
  output logic        fetch_stall_request,
  output logic        imem_request_valid,
  input  logic        imem_request_ready,
  output logic [31:0] imem_request_address,
  input  logic        imem_response_valid,
  input  logic [31:0] imem_response_data,
  output logic [31:0] id_pc,
  output logic [31:0] id_instruction,
  output logic        id_valid,
  output logic        id_misaligned
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // One circular buffer holds both in-flight requests and returned entries, in fetch order.
  logic [31:0]    slot_pc_q   [DEPTH];
  logic [31:0]    slot_pc_d   [DEPTH];
  logic [31:0]    slot_data_q [DEPTH];
  logic [31:0]    slot_data_d [DEPTH];
  logic [DEPTH-1:0] slot_done_q, slot_done_d;
  logic [DEPTH-1:0] slot_mis_q, slot_mis_d;
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d, drop_q, drop_d;
  logic [31:0]    id_pc_q, id_pc_d, id_instruction_q, id_instruction_d;
  logic           id_valid_q, id_valid_d, id_misaligned_q, id_misaligned_d;

  logic           pc_misaligned, has_credit, accept, accept_mis, alloc;
  logic           resp_hit, resp_keep, head_done, head_ready, load, pop;
  logic [PW-1:0]  resp_idx, scan_idx;
  logic [CW-1:0]  pending;
  logic           unused_stall;

`ifdef FETCH_ALIGN_CHECK_EN
  assign pc_misaligned = (pc[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  assign unused_stall = ^{stall[5:3], stall[0]};

  // Dropped-but-outstanding responses still occupy credits so memory never sees more than DEPTH.
  assign has_credit           = (count_q + drop_q) < DEPTH_C;
  assign imem_request_valid   = !reset && !flush && has_credit && !pc_misaligned;
  assign imem_request_address = pc;
  assign accept               = imem_request_valid && imem_request_ready;
  assign accept_mis           = !reset && !flush && has_credit && pc_misaligned;
  assign alloc                = accept || accept_mis;
  assign fetch_stall_request  = !alloc;

  always_comb begin
    resp_hit = 1'b0;
    resp_idx = head_q;
    scan_idx = head_q;
    pending  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && !slot_done_q[scan_idx]) begin
        pending = pending + CW'(1);
        if (!resp_hit) begin
          resp_hit = 1'b1;
          resp_idx = scan_idx;
        end
      end
    end
  end

  // A response landing on the head slot while IF/ID loads bypasses straight into IF/ID.
  assign resp_keep  = imem_response_valid && (drop_q == '0) && !flush && resp_hit;
  assign head_done  = slot_done_q[head_q];
  assign head_ready = (count_q != '0) && (head_done || (resp_keep && (resp_idx == head_q)));
  assign load       = !flush && !stall[1];
  assign pop        = load && head_ready;

  always_comb begin
    slot_pc_d        = slot_pc_q;
    slot_data_d      = slot_data_q;
    slot_done_d      = slot_done_q;
    slot_mis_d       = slot_mis_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    drop_d           = drop_q;
    id_pc_d          = id_pc_q;
    id_instruction_d = id_instruction_q;
    id_valid_d       = id_valid_q;
    id_misaligned_d  = id_misaligned_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      if (imem_response_valid && ((drop_q + pending) != '0))
        drop_d = drop_q + pending - CW'(1);
      else
        drop_d = drop_q + pending;
    end else begin
      if (imem_response_valid && (drop_q != '0))
        drop_d = drop_q - CW'(1);
      if (resp_keep) begin
        slot_data_d[resp_idx] = imem_response_data;
        slot_done_d[resp_idx] = 1'b1;
      end
      if (alloc) begin
        slot_pc_d[tail_q]   = pc;
        slot_data_d[tail_q] = '0;
        slot_done_d[tail_q] = accept_mis;
        slot_mis_d[tail_q]  = accept_mis;
        tail_d              = tail_q + PW'(1);
      end
      if (pop)
        head_d = head_q + PW'(1);
      count_d = count_q + CW'(alloc) - CW'(pop);
    end

    if (flush || (stall[1] && !stall[2])) begin
      id_pc_d          = '0;
      id_instruction_d = '0;
      id_valid_d       = 1'b0;
      id_misaligned_d  = 1'b0;
    end else if (!stall[1]) begin
      if (pop) begin
        id_pc_d          = slot_pc_q[head_q];
        id_instruction_d = head_done ? slot_data_q[head_q] : imem_response_data;
        id_valid_d       = 1'b1;
        id_misaligned_d  = slot_mis_q[head_q];
      end else begin
        id_pc_d          = '0;
        id_instruction_d = '0;
        id_valid_d       = 1'b0;
        id_misaligned_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      drop_q           <= '0;
      id_pc_q          <= '0;
      id_instruction_q <= '0;
      id_valid_q       <= 1'b0;
      id_misaligned_q  <= 1'b0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      drop_q           <= drop_d;
      id_pc_q          <= id_pc_d;
      id_instruction_q <= id_instruction_d;
      id_valid_q       <= id_valid_d;
      id_misaligned_q  <= id_misaligned_d;
    end
  end

  always_ff @(posedge clock) begin
    slot_pc_q   <= slot_pc_d;
    slot_data_q <= slot_data_d;
    slot_done_q <= slot_done_d;
    slot_mis_q  <= slot_mis_d;
  end

  assign id_pc          = id_pc_q;
  assign id_instruction = id_instruction_q;
  assign id_valid       = id_valid_q;
  assign id_misaligned  = id_misaligned_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model and a latency-modelled memory.
module tb_fetch_buffer;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] pc;
  logic        fetch_stall_request;
  logic        imem_request_valid;
  logic        imem_request_ready;
  logic [31:0] imem_request_address;
  logic        imem_response_valid;
  logic [31:0] imem_response_data;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic        id_valid;
  logic        id_misaligned;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clock                (clock),
    .reset                (reset),
    .stall                (stall),
    .flush                (flush),
    .pc                   (pc),
    .fetch_stall_request  (fetch_stall_request),
    .imem_request_valid   (imem_request_valid),
    .imem_request_ready   (imem_request_ready),
    .imem_request_address (imem_request_address),
    .imem_response_valid  (imem_response_valid),
    .imem_response_data   (imem_response_data),
    .id_pc                (id_pc),
    .id_instruction       (id_instruction),
    .id_valid             (id_valid),
    .id_misaligned        (id_misaligned)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        done;
    logic        mis;
  } entry_t;

  // Reference state: outstanding memory requests, fetch-ordered entries, drop count and IF/ID.
  memReq_t     memQ[$];
  entry_t      entQ[$];
  int          dropCnt = 0;
  logic [31:0] mIdPc = '0;
  logic [31:0] mIdInstr = '0;
  logic        mIdValid = 1'b0;
  logic        mIdMis = 1'b0;
  logic [31:0] pcReg = '0;
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h24020005;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, observed, expected, cyc);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic applyStimulus(input logic [5:0] st, input logic fl, input logic rdy,
                               input int respPct, input int latMax, input logic [31:0] flushPc);
    logic        mis, occOk, expReq, expAcc, expMisAcc, respNow;
    logic [31:0] respData;
    int          notDone;
    int          hit;
    entry_t      e;
    memReq_t     m;

    stall              = st;
    flush              = fl;
    pc                 = pcReg;
    imem_request_ready = rdy;
    respNow  = (memQ.size() > 0) && (memQ[0].due <= cyc) && (int'($urandom_range(99)) < respPct);
    respData = respNow ? memData(memQ[0].addr) : $urandom;
    imem_response_valid = respNow;
    imem_response_data  = respData;
    #2;

`ifdef FETCH_ALIGN_CHECK_EN
    mis = (pcReg[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    occOk     = (entQ.size() + dropCnt) < DEPTH;
    expReq    = !fl && occOk && !mis;
    expAcc    = expReq && rdy;
    expMisAcc = !fl && occOk && mis;

    checkOutput("req_valid", 32'(imem_request_valid), 32'(expReq));
    checkOutput("stall_req", 32'(fetch_stall_request), 32'(!(expAcc || expMisAcc)));
    checkOutput("req_addr", imem_request_address, pcReg);
    checkOutput("id_pc", id_pc, mIdPc);
    checkOutput("id_instr", id_instruction, mIdInstr);
    checkOutput("id_valid", 32'(id_valid), 32'(mIdValid));
    checkOutput("id_mis", 32'(id_misaligned), 32'(mIdMis));

    if (respNow) void'(memQ.pop_front());

    if (fl) begin
      notDone = 0;
      foreach (entQ[i]) if (!entQ[i].done) notDone++;
      dropCnt = dropCnt + notDone;
      if (respNow && dropCnt > 0) dropCnt--;
      entQ.delete();
      mIdPc = '0; mIdInstr = '0; mIdValid = 1'b0; mIdMis = 1'b0;
    end else begin
      if (respNow) begin
        if (dropCnt > 0) dropCnt--;
        else begin
          hit = -1;
          foreach (entQ[i]) if (hit < 0 && !entQ[i].done) hit = i;
          if (hit >= 0) begin
            e = entQ[hit];
            e.done = 1'b1;
            e.data = respData;
            entQ[hit] = e;
          end
        end
      end
      if (st[1] && !st[2]) begin
        mIdPc = '0; mIdInstr = '0; mIdValid = 1'b0; mIdMis = 1'b0;
      end else if (!st[1]) begin
        if (entQ.size() > 0 && entQ[0].done) begin
          e = entQ.pop_front();
          mIdPc = e.pc; mIdInstr = e.data; mIdValid = 1'b1; mIdMis = e.mis;
        end else begin
          mIdPc = '0; mIdInstr = '0; mIdValid = 1'b0; mIdMis = 1'b0;
        end
      end
      if (expAcc || expMisAcc) begin
        e.pc = pcReg; e.data = '0; e.done = expMisAcc; e.mis = expMisAcc;
        entQ.push_back(e);
      end
    end

    if (expAcc) begin
      m.addr = pcReg;
      m.due  = cyc + 1 + int'($urandom_range(latMax));
      memQ.push_back(m);
    end

    if (fl) pcReg = flushPc;
    else if (expAcc || expMisAcc) pcReg = pcReg + 32'd4;

    cyc++;
    @(posedge clock);
    #1;
  endtask

  // Reset check, directed scenarios, randomized traffic, then drain.
  initial begin
    logic [5:0]  st;
    logic [31:0] target;
    int          lat;

    reset = 1'b1;
    stall = '0;
    flush = 1'b0;
    pc = '0;
    imem_request_ready = 1'b1;
    imem_response_valid = 1'b0;
    imem_response_data = '0;
    @(posedge clock);
    @(posedge clock);
    #2;
    checkOutput("rst_stall_req", 32'(fetch_stall_request), 32'd1);
    checkOutput("rst_req_valid", 32'(imem_request_valid), 32'd0);
    checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
    checkOutput("rst_id_pc", id_pc, 32'd0);
    checkOutput("rst_id_instr", id_instruction, 32'd0);
    checkOutput("rst_id_mis", 32'(id_misaligned), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 4; i++) applyStimulus(6'b000000, 1'b0, 1'b1, 100, 0, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(6'b000000, 1'b0, 1'b0, 100, 0, 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(6'b000110, 1'b0, 1'b1, 100, 0, 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(6'b000000, 1'b0, 1'b1, 100, 0, 32'd0);
    for (int i = 0; i < 2; i++) applyStimulus(6'b000010, 1'b0, 1'b1, 100, 0, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(6'b000000, 1'b0, 1'b1, 100, 0, 32'd0);

    for (int i = 0; i < 2; i++) applyStimulus(6'b000000, 1'b0, 1'b1, 0, 2, 32'd0);
    applyStimulus(6'b000000, 1'b1, 1'b1, 0, 0, 32'h80);
    for (int i = 0; i < 10; i++) applyStimulus(6'b000000, 1'b0, 1'b1, 100, 0, 32'd0);

    applyStimulus(6'b000000, 1'b1, 1'b1, 100, 0, 32'h6);
    for (int i = 0; i < 6; i++) applyStimulus(6'b000000, 1'b0, 1'b1, 100, 0, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      st = 6'($urandom) & 6'b111001;
      if ($urandom_range(3) == 0) st[1] = 1'b1;
      st[2] = 1'($urandom);
      lat = (i < 1500) ? 1 : 3;
      target = {22'd0, 8'($urandom), 2'b00};
      if ($urandom_range(7) == 0) target = target | 32'h2;
      applyStimulus(st, ($urandom_range(24) == 0), ($urandom_range(9) < 7), 70, lat, target);
    end

    for (int i = 0; i < 20; i++) applyStimulus(6'b000000, 1'b0, 1'b0, 100, 0, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
